// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter generator.
package pc_gen_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int IALIGN_32    = 32;
  localparam int IALIGN_16    = 16;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JALR,
    SRC_TRAP,
    SRC_PENDING
  } pc_src_e;

  // Only the two low address bits matter for either alignment mode.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input int ialign);
    return (ialign == IALIGN_16) ? addr_lo[0] : (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target arithmetic: sequential, PC-relative and register-relative
// targets plus their alignment flags.
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = IALIGN_32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] br_tgt_o,
  output logic [XLEN-1:0] jalr_tgt_o,
  output logic            br_misaligned_o,
  output logic            jalr_misaligned_o
);

  logic [XLEN-1:0] jalr_sum;

  assign pc_plus4_o = pc_i + XLEN'(4);
  assign br_tgt_o   = pc_i + imm_i;
  assign jalr_sum   = rs1_i + imm_i;
  assign jalr_tgt_o = {jalr_sum[XLEN-1:1], 1'b0};

  assign br_misaligned_o   = is_misaligned(br_tgt_o[1:0], IALIGN);
  assign jalr_misaligned_o = is_misaligned(jalr_tgt_o[1:0], IALIGN);

endmodule

// File: rtl/pc_gen.sv
// Program-counter register with trap/jump/branch/sequential arbitration,
// alignment rejection and a redirect holding register for stalls.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = IALIGN_32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_target,
  output logic            redirect_pending
);

  if (IALIGN != IALIGN_32 && IALIGN != IALIGN_16) begin : g_bad_ialign
    $error("pc_gen: IALIGN must be 16 or 32");
  end
  if (is_misaligned(RESET_VECTOR[1:0], IALIGN)) begin : g_bad_reset_vector
    $error("pc_gen: RESET_VECTOR is not IALIGN-aligned");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] bad_q, bad_d;

  logic [XLEN-1:0] br_tgt, jalr_tgt, jump_tgt;
  logic            br_mis, jalr_mis, jump_mis;
  logic            jump_req, jump_considered, jump_ok;
  pc_src_e         src;

  pc_target_calc #(
    .XLEN  (XLEN),
    .IALIGN(IALIGN)
  ) u_calc (
    .pc_i             (pc_q),
    .rs1_i            (rs1),
    .imm_i            (immediate),
    .pc_plus4_o       (pc_plus4),
    .br_tgt_o         (br_tgt),
    .jalr_tgt_o       (jalr_tgt),
    .br_misaligned_o  (br_mis),
    .jalr_misaligned_o(jalr_mis)
  );

  assign jump_req = jalr | jal | branch_taken;
  assign jump_tgt = jalr ? jalr_tgt : br_tgt;
  assign jump_mis = jalr ? jalr_mis : br_mis;
  // A jump only counts when neither a trap nor an older held redirect outranks it.
  assign jump_considered = jump_req & ~trap_valid & ~pend_q;
  assign jump_ok         = jump_considered & ~jump_mis;

  always_comb begin
    src        = SRC_SEQ;
    pc_d       = pc_q;
    pend_d     = 1'b0;
    pend_tgt_d = pend_tgt_q;
    mis_d      = jump_considered & jump_mis;
    bad_d      = (jump_considered & jump_mis) ? jump_tgt : bad_q;

    if (trap_valid)   src = SRC_TRAP;
    else if (pend_q)  src = SRC_PENDING;
    else if (jalr)    src = SRC_JALR;
    else if (jump_req) src = SRC_BRANCH;

    if (stall) begin
      pend_d = pend_q;
      if (trap_valid) begin
        pend_d     = 1'b1;
        pend_tgt_d = trap_vector;
      end else if (jump_ok) begin
        pend_d     = 1'b1;
        pend_tgt_d = jump_tgt;
      end
    end else begin
      unique case (src)
        SRC_TRAP:    pc_d = trap_vector;
        SRC_PENDING: pc_d = pend_tgt_q;
        SRC_JALR:    pc_d = jump_mis ? pc_q : jalr_tgt;
        SRC_BRANCH:  pc_d = jump_mis ? pc_q : br_tgt;
        default:     pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      mis_q      <= 1'b0;
      bad_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      mis_q      <= mis_d;
      bad_q      <= bad_d;
    end
  end

  assign pc               = pc_q;
  assign branch_target    = br_tgt;
  assign misaligned       = mis_q;
  assign bad_target       = bad_q;
  assign redirect_pending = pend_q;

endmodule
